// File: rtl/sort_pkg.sv
// Shared definitions for the sort datapath and its UART-side scheduler.
//   tx_sched_state_t  : sort_tx_scheduler FSM encoding
//   DEFAULT_TERM_BYTE : line-feed terminator appended after each array
//   bytes_per_seq()   : number of bytes in one sorted sequence
package sort_pkg;

    typedef enum logic [2:0] {
        TX_IDLE,
        TX_ISSUE,
        TX_WAIT_ACK,
        TX_WAIT_DONE,
        TX_TERM,
        TX_FINISH
    } tx_sched_state_t;

    localparam logic [7:0] DEFAULT_TERM_BYTE = 8'h0A;

    function automatic int bytes_per_seq(input int width, input int depth);
        return depth * (width / 8);
    endfunction

endpackage

// File: rtl/sort_tx_scheduler_if.sv
// Handshake bundle between sort_top, the scheduler and uart_tx.
//   valid_in/sorted : sorted-array delivery from sort_top
//   tx_busy         : frame-in-progress flag from uart_tx
//   tx_data/tx_start: byte request to uart_tx
//   ready/done/overrun : scheduler status
// modport slave  : the scheduler itself
// modport master : the environment driving it (sort_top + uart_tx)
interface sort_tx_scheduler_if #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 8
) ();

    logic                              valid_in;
    logic [0:DEPTH-1][0:WIDTH-1]       sorted;
    logic                              tx_busy;
    logic [7:0]                        tx_data;
    logic                              tx_start;
    logic                              ready;
    logic                              done;
    logic                              overrun;

    modport slave (
        input  valid_in, sorted, tx_busy,
        output tx_data, tx_start, ready, done, overrun
    );

    modport master (
        output valid_in, sorted, tx_busy,
        input  tx_data, tx_start, ready, done, overrun
    );

endinterface

// File: rtl/sort_tx_scheduler.sv
// Streams a captured DEPTH x WIDTH sorted array to uart_tx one byte at a
// time (element 0 first, MSB byte first), optionally followed by a
// terminator byte.
//   clk  : system clock
//   rst  : asynchronous, active-low reset
//   bus  : sort_tx_scheduler_if.slave (valid_in, sorted, tx_busy in;
//          tx_data, tx_start, ready, done, overrun out)
// All outputs are registered; tx_start/tx_data are loaded on the edge
// that enters ISSUE/TERM so the request is visible for exactly that state.
module sort_tx_scheduler
    import sort_pkg::*;
#(
    parameter int         WIDTH     = 32,
    parameter int         DEPTH     = 8,
    parameter bit         SEND_TERM = 1'b1,
    parameter logic [7:0] TERM_BYTE = DEFAULT_TERM_BYTE
) (
    input  logic                 clk,
    input  logic                 rst,
    sort_tx_scheduler_if.slave   bus
);

    localparam int          NB    = bytes_per_seq(WIDTH, DEPTH);
    localparam int unsigned BPE   = WIDTH / 8;
    localparam int          IDX_W = (NB > 1) ? $clog2(NB) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NB - 1);

    if ((WIDTH % 8) != 0) begin : g_width_chk
        $error("sort_tx_scheduler: WIDTH must be a multiple of 8");
    end

    tx_sched_state_t               state_q;
    logic [0:DEPTH-1][0:WIDTH-1]   shadow_q;
    logic [IDX_W-1:0]              idx_q;
    logic                          term_q;
    logic [7:0]                    tx_data_q;
    logic                          tx_start_q;
    logic                          ready_q;
    logic                          done_q;
    logic                          overrun_q;

    // Byte that follows idx_q, chosen by element (idx/BPE) then byte within
    // the element (idx%BPE). Element 0 occupies the top of the flat vector.
    logic [NB*8-1:0]   shadow_flat;
    logic [IDX_W-1:0]  nxt_idx;
    int unsigned       elem_sel;
    int unsigned       byte_sel;
    logic [WIDTH-1:0]  elem_word;
    logic [7:0]        next_byte;

    assign shadow_flat = shadow_q;

    always_comb begin
        nxt_idx   = idx_q + 1'b1;
        elem_sel  = 32'(nxt_idx) / BPE;
        byte_sel  = 32'(nxt_idx) % BPE;
        elem_word = WIDTH'(shadow_flat >> ((DEPTH - 1 - elem_sel) * WIDTH));
        next_byte = 8'(elem_word >> ((BPE - 1 - byte_sel) * 8));
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= TX_IDLE;
            shadow_q   <= '0;
            idx_q      <= '0;
            term_q     <= 1'b0;
            tx_data_q  <= '0;
            tx_start_q <= 1'b0;
            ready_q    <= 1'b1;
            done_q     <= 1'b0;
            overrun_q  <= 1'b0;
        end else begin
            tx_start_q <= 1'b0;
            done_q     <= 1'b0;

            if (bus.valid_in && (state_q != TX_IDLE)) begin
                overrun_q <= 1'b1;
            end

            case (state_q)
                TX_IDLE: begin
                    if (bus.valid_in) begin
                        // Byte 0 comes straight from the input so tx_start
                        // can go out the cycle after valid_in.
                        shadow_q   <= bus.sorted;
                        idx_q      <= '0;
                        term_q     <= 1'b0;
                        tx_data_q  <= bus.sorted[0][0:7];
                        tx_start_q <= 1'b1;
                        ready_q    <= 1'b0;
                        state_q    <= TX_ISSUE;
                    end
                end
                TX_ISSUE, TX_TERM: begin
                    state_q <= TX_WAIT_ACK;
                end
                TX_WAIT_ACK: begin
                    if (bus.tx_busy) begin
                        state_q <= TX_WAIT_DONE;
                    end
                end
                TX_WAIT_DONE: begin
                    if (!bus.tx_busy) begin
                        if (term_q) begin
                            done_q  <= 1'b1;
                            state_q <= TX_FINISH;
                        end else if (idx_q != LAST_IDX) begin
                            idx_q      <= nxt_idx;
                            tx_data_q  <= next_byte;
                            tx_start_q <= 1'b1;
                            state_q    <= TX_ISSUE;
                        end else if (SEND_TERM) begin
                            term_q     <= 1'b1;
                            tx_data_q  <= TERM_BYTE;
                            tx_start_q <= 1'b1;
                            state_q    <= TX_TERM;
                        end else begin
                            done_q  <= 1'b1;
                            state_q <= TX_FINISH;
                        end
                    end
                end
                TX_FINISH: begin
                    ready_q <= 1'b1;
                    state_q <= TX_IDLE;
                end
                default: begin
                    ready_q <= 1'b1;
                    state_q <= TX_IDLE;
                end
            endcase
        end
    end

    assign bus.tx_data  = tx_data_q;
    assign bus.tx_start = tx_start_q;
    assign bus.ready    = ready_q;
    assign bus.done     = done_q;
    assign bus.overrun  = overrun_q;

endmodule

// File: tb/tb_sort_tx_scheduler.sv
module tb_sort_tx_scheduler;

    logic clk;
    logic rst_n;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    sort_tx_scheduler_if #(.WIDTH(32), .DEPTH(8)) ifa ();
    sort_tx_scheduler_if #(.WIDTH(16), .DEPTH(4)) ifb ();

    sort_tx_scheduler #(
        .WIDTH(32), .DEPTH(8), .SEND_TERM(1'b1), .TERM_BYTE(8'h0A)
    ) dut_a (
        .clk(clk), .rst(rst_n), .bus(ifa.slave)
    );

    sort_tx_scheduler #(
        .WIDTH(16), .DEPTH(4), .SEND_TERM(1'b0), .TERM_BYTE(8'h0A)
    ) dut_b (
        .clk(clk), .rst(rst_n), .bus(ifb.slave)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check_eq(input string tag, input logic [63:0] got,
                            input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // uart_tx models: A raises busy on the start edge for 20 cycles,
    // B raises busy one cycle late and holds it for 5 cycles.
    int a_cnt, b_cnt;
    logic b_pend;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ifa.tx_busy <= 1'b0;
            a_cnt       <= 0;
        end else if (ifa.tx_start) begin
            ifa.tx_busy <= 1'b1;
            a_cnt       <= 19;
        end else if (a_cnt != 0) begin
            a_cnt <= a_cnt - 1;
        end else begin
            ifa.tx_busy <= 1'b0;
        end
    end

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ifb.tx_busy <= 1'b0;
            b_cnt       <= 0;
            b_pend      <= 1'b0;
        end else if (ifb.tx_start) begin
            b_pend <= 1'b1;
        end else if (b_pend) begin
            b_pend      <= 1'b0;
            ifb.tx_busy <= 1'b1;
            b_cnt       <= 4;
        end else if (b_cnt != 0) begin
            b_cnt <= b_cnt - 1;
        end else begin
            ifb.tx_busy <= 1'b0;
        end
    end

    // Monitors: collect issued bytes, count done pulses, flag any start
    // issued back-to-back, while busy, or before busy acknowledged a start.
    logic [7:0] a_bytes[$];
    logic [7:0] b_bytes[$];
    int a_starts = 0, a_dones = 0, a_viol = 0;
    int b_starts = 0, b_dones = 0, b_viol = 0;
    logic a_prev = 1'b0, a_wait = 1'b0;
    logic b_prev = 1'b0, b_wait = 1'b0;

    always @(posedge clk) begin
        if (rst_n) begin
            if (ifa.tx_start) begin
                a_bytes.push_back(ifa.tx_data);
                a_starts++;
                if (ifa.tx_busy || a_prev || a_wait) a_viol++;
            end
            if (ifa.done) a_dones++;
            a_wait = ifa.tx_start ? 1'b1 : (ifa.tx_busy ? 1'b0 : a_wait);
            a_prev = ifa.tx_start;

            if (ifb.tx_start) begin
                b_bytes.push_back(ifb.tx_data);
                b_starts++;
                if (ifb.tx_busy || b_prev || b_wait) b_viol++;
            end
            if (ifb.done) b_dones++;
            b_wait = ifb.tx_start ? 1'b1 : (ifb.tx_busy ? 1'b0 : b_wait);
            b_prev = ifb.tx_start;
        end else begin
            a_prev = 1'b0; a_wait = 1'b0;
            b_prev = 1'b0; b_wait = 1'b0;
        end
    end

    // Array the A stream is expected to carry (captured value).
    logic [31:0] wa [8];

    task automatic drive_a();
        for (int i = 0; i < 8; i++) ifa.sorted[i] = wa[i];
    endtask

    task automatic pulse_a();
        ifa.valid_in = 1'b1;
        @(negedge clk);
        ifa.valid_in = 1'b0;
    endtask

    task automatic expect_stream_a(input string tag, input int base);
        logic [7:0] exp;
        check_eq({tag, "_count"}, 64'(a_bytes.size() - base), 64'd33);
        for (int j = 0; j < 33; j++) begin
            if (j == 32) exp = 8'h0A;
            else         exp = 8'(wa[j / 4] >> (8 * (3 - (j % 4))));
            if (base + j < a_bytes.size())
                check_eq($sformatf("%s_b%0d", tag, j), 64'(a_bytes[base + j]), 64'(exp));
        end
    endtask

    task automatic wait_done_a(input string tag);
        bit seen = 1'b0;
        for (int c = 0; c < 3000 && !seen; c++) begin
            @(negedge clk);
            if (ifa.done) seen = 1'b1;
        end
        if (!seen) check_eq({tag, "_timeout"}, 64'd0, 64'd1);
    endtask

    task automatic wait_starts_a(input string tag, input int target);
        bit seen = 1'b0;
        for (int c = 0; c < 3000 && !seen; c++) begin
            @(negedge clk);
            if (a_starts >= target) seen = 1'b1;
        end
        if (!seen) check_eq({tag, "_timeout"}, 64'd0, 64'd1);
    endtask

    task automatic set_counting();
        for (int i = 0; i < 8; i++) wa[i] = 32'(i + 1);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int base, s0, d0;
        logic [7:0] exp_b [8];
        bit seen;

        rst_n = 1'b0;
        ifa.valid_in = 1'b0; ifa.sorted = '0;
        ifb.valid_in = 1'b0; ifb.sorted = '0;
        repeat (3) @(negedge clk);

        // Reset state
        check_eq("rst_tx_data", 64'(ifa.tx_data), 64'h0);
        check_eq("rst_tx_start", 64'(ifa.tx_start), 64'd0);
        check_eq("rst_ready", 64'(ifa.ready), 64'd1);
        check_eq("rst_done", 64'(ifa.done), 64'd0);
        check_eq("rst_overrun", 64'(ifa.overrun), 64'd0);
        check_eq("rst_ready_b", 64'(ifb.ready), 64'd1);
        rst_n = 1'b1;
        @(negedge clk);

        // T1: counting array, terminator, latency and done/ready timing
        set_counting(); drive_a();
        base = a_bytes.size(); d0 = a_dones;
        pulse_a();
        check_eq("t1_start_lat", 64'(ifa.tx_start), 64'd1);
        check_eq("t1_byte0", 64'(ifa.tx_data), 64'h00);
        check_eq("t1_ready_low", 64'(ifa.ready), 64'd0);
        wait_done_a("t1_done");
        check_eq("t1_ready_at_done", 64'(ifa.ready), 64'd0);
        @(negedge clk);
        check_eq("t1_ready_after", 64'(ifa.ready), 64'd1);
        check_eq("t1_done_pulse", 64'(ifa.done), 64'd0);
        check_eq("t1_done_count", 64'(a_dones - d0), 64'd1);
        check_eq("t1_overrun", 64'(ifa.overrun), 64'd0);
        expect_stream_a("t1", base);

        // T2: DEADBEEF ordering; input changed after capture
        set_counting(); wa[0] = 32'hDEADBEEF; drive_a();
        base = a_bytes.size();
        pulse_a();
        ifa.sorted = '1;
        wait_done_a("t2_done");
        @(negedge clk);
        expect_stream_a("t2", base);

        // T3: second valid_in during byte 5 is dropped
        set_counting(); drive_a();
        base = a_bytes.size(); s0 = a_starts; d0 = a_dones;
        pulse_a();
        wait_starts_a("t3_byte5", s0 + 6);
        repeat (3) @(negedge clk);
        ifa.sorted = '0;
        pulse_a();
        check_eq("t3_overrun_set", 64'(ifa.overrun), 64'd1);
        wait_done_a("t3_done");
        @(negedge clk);
        expect_stream_a("t3", base);
        check_eq("t3_overrun_sticky", 64'(ifa.overrun), 64'd1);
        check_eq("t3_done_count", 64'(a_dones - d0), 64'd1);

        // T4: valid_in on FINISH dropped; valid_in in next IDLE cycle accepted
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        check_eq("t4_overrun_clr", 64'(ifa.overrun), 64'd0);
        @(negedge clk);
        set_counting(); drive_a();
        pulse_a();
        wait_done_a("t4_done");
        for (int i = 0; i < 8; i++) wa[i] = 32'hA0B0C0D0 + 32'(i);
        drive_a();
        pulse_a();
        check_eq("t4_overrun_finish", 64'(ifa.overrun), 64'd1);
        check_eq("t4_no_start", 64'(ifa.tx_start), 64'd0);
        check_eq("t4_ready_idle", 64'(ifa.ready), 64'd1);
        base = a_bytes.size();
        pulse_a();
        check_eq("t4_accept_start", 64'(ifa.tx_start), 64'd1);
        check_eq("t4_accept_byte0", 64'(ifa.tx_data), 64'hA0);
        wait_done_a("t4_done2");
        @(negedge clk);
        expect_stream_a("t4", base);

        // T5: asynchronous reset mid-byte 10
        set_counting(); drive_a();
        s0 = a_starts;
        pulse_a();
        wait_starts_a("t5_byte10", s0 + 11);
        repeat (5) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check_eq("t5_rst_tx_data", 64'(ifa.tx_data), 64'h0);
        check_eq("t5_rst_tx_start", 64'(ifa.tx_start), 64'd0);
        check_eq("t5_rst_ready", 64'(ifa.ready), 64'd1);
        check_eq("t5_rst_done", 64'(ifa.done), 64'd0);
        check_eq("t5_rst_overrun", 64'(ifa.overrun), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        s0 = a_starts;
        repeat (60) @(negedge clk);
        check_eq("t5_quiet_starts", 64'(a_starts - s0), 64'd0);
        for (int i = 0; i < 8; i++) wa[i] = 32'h01020304 * 32'(i + 1);
        drive_a();
        base = a_bytes.size();
        pulse_a();
        check_eq("t5_restart", 64'(ifa.tx_start), 64'd1);
        wait_done_a("t5_done");
        @(negedge clk);
        expect_stream_a("t5", base);

        // T6: WIDTH=16 DEPTH=4 no terminator, late busy
        exp_b = '{8'h12, 8'h34, 8'h56, 8'h78, 8'h9A, 8'hBC, 8'hDE, 8'hF0};
        ifb.sorted[0] = 16'h1234; ifb.sorted[1] = 16'h5678;
        ifb.sorted[2] = 16'h9ABC; ifb.sorted[3] = 16'hDEF0;
        base = b_bytes.size(); d0 = b_dones;
        ifb.valid_in = 1'b1;
        @(negedge clk);
        ifb.valid_in = 1'b0;
        check_eq("t6_start_lat", 64'(ifb.tx_start), 64'd1);
        check_eq("t6_byte0", 64'(ifb.tx_data), 64'h12);
        seen = 1'b0;
        for (int c = 0; c < 1000 && !seen; c++) begin
            @(negedge clk);
            if (ifb.done) seen = 1'b1;
        end
        if (!seen) check_eq("t6_done_timeout", 64'd0, 64'd1);
        @(negedge clk);
        check_eq("t6_count", 64'(b_bytes.size() - base), 64'd8);
        for (int j = 0; j < 8; j++)
            if (base + j < b_bytes.size())
                check_eq($sformatf("t6_b%0d", j), 64'(b_bytes[base + j]), 64'(exp_b[j]));
        check_eq("t6_done_count", 64'(b_dones - d0), 64'd1);
        check_eq("t6_overrun", 64'(ifb.overrun), 64'd0);
        check_eq("t6_ready", 64'(ifb.ready), 64'd1);

        check_eq("a_start_rules", 64'(a_viol), 64'd0);
        check_eq("b_start_rules", 64'(b_viol), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
